mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter that shares the single-ported `dataMemory` line interface between the instruction cache (port I) and the data cache (port D). It grants one requester at a time and drives the memory's `Address`/`Line_in`/`Read`/`Write` from registers. It holds the memory request until `Ready`, returns the line and a one-cycle done pulse to the winner, then inserts a release cycle so the memory's latency pipeline clears. Arbitration is round-robin, with D favoured after reset.

## Interface
- `ADDR_W`, default 28: line address width (`WORD_SIZE`-`INDEX_SIZE`).
- `LINE_W`, default 128: cache line width (`CACHE_LINE_SIZE`).
- `clk`  in  1: single clock, all state on rising edge.
- `rst`  in  1: synchronous reset, active-high.
- `i_read`  in  1: I-port read request, held until `i_ready`.
- `i_addr`  in  ADDR_W: I-port line address.
- `i_ready`  out  1: one-cycle completion pulse to I.
- `i_line`  out  LINE_W: line returned to I; valid while `i_ready`=1 and held until the next I completion.
- `d_read`, `d_write`  in  1 each: D-port requests, held until `d_ready`.
- `d_addr`  in  ADDR_W: D-port line address.
- `d_wline`  in  LINE_W: D-port write data.
- `d_ready`  out  1: one-cycle completion pulse to D.
- `d_line`  out  LINE_W: line returned to D on reads; same validity as `i_line`.
- `mem_read`, `mem_write`  out  1: to memory `Read`/`Write`. Registered, never both 1.
- `mem_addr`  out  ADDR_W; `mem_wline`  out  LINE_W: to memory `Address`/`Line_in`. Registered.
- `mem_ready`  in  1; `mem_rline`  in  LINE_W: from memory `Ready`/`Line_out`.
- `busy`  out  1: state ≠ IDLE.
- `gnt_d`  out  1: current or most recent grant is D.

## Operation
- FSM states: IDLE, BUSY, RELEASE. Register `last` records the last granted port; its reset value is I.
- IDLE: sample requests. A port is requesting if `i_read`=1, or if `d_read`|`d_write`=1.
  - Only one port requesting: grant it.
  - Both requesting: grant the port ≠ `last`.
  - On grant: latch address, write data and operation into `mem_*`; set `gnt_d`; update `last`; go to BUSY.
- D with `d_read`=`d_write`=1: treat as a write.
- BUSY: hold all `mem_*` outputs constant and ignore all requester inputs. When `mem_ready`=1:
  - clear `mem_read`/`mem_write`;
  - capture `mem_rline` into `i_line` or `d_line` (reads only; `d_line` is unchanged on writes);
  - pulse the granted port's ready;
  - go to RELEASE.
- RELEASE: one cycle with `mem_read`=`mem_write`=0, so the memory clears F0–F3 and `Ready`. Then go to IDLE unconditionally.
- `mem_ready` is ignored outside BUSY.
- No timeout: BUSY waits indefinitely for `mem_ready`.
- Reset (any state, including mid-transfer):
  - state IDLE, `last`=I;
  - all outputs 0, including `i_line`, `d_line`, `mem_addr`, `mem_wline` and `gnt_d`.
  - An in-flight memory access is abandoned. The memory sees `Read`/`Write`=0 on the next edge and clears itself. A write abandoned before the memory's F2 stage is not committed.

## Timing
- Request sampled at edge E0 → `mem_read`/`mem_write` high after E0.
- Memory `Ready` rises after E5. Arbiter sees it at E6 → `x_ready`=1 and the line is valid during E6–E7. Memory `Ready` falls after E7 (RELEASE). Arbiter is in IDLE after E7.
- Requester must deassert its request on the edge at which it samples `x_ready`=1 (E7). The arbiter next samples requests at E8.
- Latency: request to ready = 6 cycles. Back-to-back grant period = 8 cycles.
- Both requesting continuously: grants alternate D, I, D, I… starting with D after reset.
- A request that arrives during BUSY or RELEASE waits; nothing is lost, since the request is level-held.

## Test plan
- Reset, then I read of addr 0x10 alone → `mem_read`=1, `mem_addr`=0x10 after E0; `i_ready` pulses exactly at E6 with `i_line`=mem[0x10]; `d_ready` stays 0.
- D write of 0xDEAD…BEEF to addr 0x20, then D read of 0x20 → write completes at E6 with `d_line` unchanged; read returns 0xDEAD…BEEF; the two grants are 8 cycles apart.
- I and D both assert at the first IDLE after reset → D granted first, I granted at E8, I done at E14; `gnt_d` is 1 then 0.
- Both held continuously for 4 transactions → grant order D, I, D, I; never two consecutive grants to the same port.
- `d_read`=`d_write`=1 → `mem_write`=1, `mem_read`=0 throughout; the write is performed.
- `rst` asserted at E3 during a D write → all outputs 0 after E3; memory not written; a subsequent I request is granted normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares a single-ported line memory between the instruction
// cache (port I, read-only) and the data cache (port D, read/write).
// One requester is served at a time. Arbitration is round-robin, and D wins
// the first tie after reset. Each transfer ends with a one-cycle release
// state that lets the memory's latency pipeline drain before the next grant.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   i_read, i_addr        I-port read request (level, held until i_ready)
//   i_ready, i_line       I completion pulse / returned line (held)
//   d_read, d_write       D-port requests (level, held until d_ready)
//   d_addr, d_wline       D-port line address / write data
//   d_ready, d_line       D completion pulse / returned read line (held)
//   mem_read, mem_write   registered memory Read/Write strobes
//   mem_addr, mem_wline   registered memory Address/Line_in
//   mem_ready, mem_rline  memory Ready/Line_out
//   busy                  arbiter is not idle
//   gnt_d                 current or most recent grant went to D
module mem_arbiter #(
  parameter int unsigned ADDR_W = 28,
  parameter int unsigned LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  output logic [LINE_W-1:0] i_line,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wline,
  output logic              d_ready,
  output logic [LINE_W-1:0] d_line,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wline,
  input  logic              mem_ready,
  input  logic [LINE_W-1:0] mem_rline,
  output logic              busy,
  output logic              gnt_d
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t state, state_n;
  logic   last_d;   // last grant went to D (reset: I, so D wins the first tie)
  logic   i_req, d_req;
  logic   pick_d;
  logic   grant;
  logic   done;

  always_comb begin
    i_req   = i_read;
    d_req   = d_read | d_write;
    // D wins when it is the only requester, or on a tie when I was served last.
    pick_d  = d_req & (~i_req | ~last_d);
    grant   = 1'b0;
    done    = 1'b0;
    state_n = state;
    case (state)
      IDLE: begin
        if (i_req || d_req) begin
          grant   = 1'b1;
          state_n = BUSY;
        end
      end
      BUSY: begin
        if (mem_ready) begin
          done    = 1'b1;
          state_n = RELEASE;
        end
      end
      RELEASE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      last_d    <= 1'b0;
      gnt_d     <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wline <= '0;
      i_ready   <= 1'b0;
      d_ready   <= 1'b0;
      i_line    <= '0;
      d_line    <= '0;
    end else begin
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      if (grant) begin
        gnt_d  <= pick_d;
        last_d <= pick_d;
        if (pick_d) begin
          // Read and write together is treated as a write.
          mem_addr  <= d_addr;
          mem_wline <= d_wline;
          mem_write <= d_write;
          mem_read  <= ~d_write;
        end else begin
          mem_addr  <= i_addr;
          mem_wline <= '0;
          mem_write <= 1'b0;
          mem_read  <= 1'b1;
        end
      end
      if (done) begin
        mem_read  <= 1'b0;
        mem_write <= 1'b0;
        if (gnt_d) begin
          d_ready <= 1'b1;
          // mem_write still holds the operation of the finishing transfer.
          if (!mem_write) begin
            d_line <= mem_rline;
          end
        end else begin
          i_ready <= 1'b1;
          i_line  <= mem_rline;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a behavioural line memory with a
// fixed 5-edge Ready latency, a transaction-level reference model compared
// every cycle, and directed transactions with literal expectations.
module tb_mem_arbiter;
  localparam int unsigned AW = 28;
  localparam int unsigned LW = 128;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_read, d_read, d_write;
  logic [AW-1:0] i_addr, d_addr;
  logic [LW-1:0] d_wline;
  logic          i_ready, d_ready;
  logic [LW-1:0] i_line, d_line;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [LW-1:0] mem_wline;
  logic          mem_ready = 1'b0;
  logic [LW-1:0] mem_rline = '0;
  logic          busy, gnt_d;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;
  bit          chk_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr), .i_ready(i_ready), .i_line(i_line),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wline(d_wline),
    .d_ready(d_ready), .d_line(d_line),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wline(mem_wline), .mem_ready(mem_ready), .mem_rline(mem_rline),
    .busy(busy), .gnt_d(gnt_d)
  );

  function automatic logic [LW-1:0] init_line(input logic [7:0] a);
    return {4{24'hC0DE00, a}};
  endfunction

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- memory environment ----------------
  logic [LW-1:0] env_mem [256];
  bit            env_wr  [256];
  int unsigned   env_cnt = 0;

  always @(posedge clk) begin
    if (mem_read || mem_write) begin
      if (env_cnt == 4) begin
        mem_ready <= 1'b1;
        if (mem_read)
          mem_rline <= env_wr[mem_addr[7:0]] ? env_mem[mem_addr[7:0]] : init_line(mem_addr[7:0]);
        else begin
          env_mem[mem_addr[7:0]] <= mem_wline;
          env_wr[mem_addr[7:0]]  <= 1'b1;
        end
      end
      env_cnt <= env_cnt + 1;
    end else begin
      env_cnt   <= 0;
      mem_ready <= 1'b0;
    end
  end

  // ---------------- reference model ----------------
  // m_age = edges since the grant edge; -1 when idle. A transfer is fixed at
  // strobes for ages 0..5, ready at age 6, back to idle at age 7.
  int            m_age = -1;
  logic          m_last_d, m_port_d, m_write;
  logic [AW-1:0] m_addr;
  logic [LW-1:0] m_wline, m_i_line, m_d_line;
  logic [LW-1:0] m_mem [256];
  bit            m_wr  [256];

  function automatic logic [LW-1:0] model_read(input logic [7:0] a);
    return m_wr[a] ? m_mem[a] : init_line(a);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_age = -1; m_last_d = 1'b0; m_port_d = 1'b0; m_write = 1'b0;
      m_addr = '0; m_wline = '0; m_i_line = '0; m_d_line = '0;
    end else if (m_age < 0) begin
      if (i_read || d_read || d_write) begin
        m_port_d = (d_read || d_write) && !(i_read && m_last_d);
        m_last_d = m_port_d;
        m_write  = m_port_d && d_write;
        m_addr   = m_port_d ? d_addr : i_addr;
        m_wline  = m_port_d ? d_wline : '0;
        m_age    = 0;
      end
    end else begin
      m_age++;
      if (m_age == 6) begin
        if (m_write) begin
          m_mem[m_addr[7:0]] = m_wline;
          m_wr[m_addr[7:0]]  = 1'b1;
        end else if (m_port_d) m_d_line = model_read(m_addr[7:0]);
        else m_i_line = model_read(m_addr[7:0]);
      end else if (m_age == 7) m_age = -1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", busy, m_age >= 0);
      chk("gnt_d", gnt_d, m_port_d);
      chk("mem_read", mem_read, m_age >= 0 && m_age <= 5 && !m_write);
      chk("mem_write", mem_write, m_age >= 0 && m_age <= 5 && m_write);
      chk("mem_addr", mem_addr, m_addr);
      if (m_port_d) chk("mem_wline", mem_wline, m_wline);
      chk("i_ready", i_ready, m_age == 6 && !m_port_d);
      chk("d_ready", d_ready, m_age == 6 && m_port_d);
      chk("i_line", i_line, m_i_line);
      chk("d_line", d_line, m_d_line);
    end
  end

  // grant log: records which port won each time busy rises
  bit          prev_busy = 1'b0;
  bit          gnt_log [$];
  always @(negedge clk) begin
    if (busy && !prev_busy) gnt_log.push_back(gnt_d);
    prev_busy = busy;
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_ready(input bit want_d, output int unsigned at);
    bit ok = 1'b0;
    at = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (want_d ? d_ready : i_ready) begin ok = 1'b1; at = cyc; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL ready_timeout: got no %s ready expected pulse within 40 cycles", want_d ? "d" : "i");
    end
  endtask

  task automatic run_txn(input bit is_d, input bit rd, input bit wr, input logic [AW-1:0] a,
                         input logic [LW-1:0] wd, output int unsigned t0,
                         output int unsigned lat, output logic [LW-1:0] line);
    int unsigned at;
    @(negedge clk);
    if (is_d) begin d_read = rd; d_write = wr; d_addr = a; d_wline = wd; end
    else begin i_read = 1'b1; i_addr = a; end
    t0 = cyc + 1;
    @(negedge clk);
    chk("lit_strobe_write", mem_write, is_d && wr);
    chk("lit_strobe_read", mem_read, !(is_d && wr));
    chk("lit_addr", mem_addr, a);
    wait_ready(is_d, at);
    lat = at - t0;
    line = is_d ? d_line : i_line;
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int unsigned t0, t1, lat, td, ti, at, base;
    logic [LW-1:0] line;
    logic [LW-1:0] pat_a, pat_b, pat_c;
    int            nd;
    pat_a = 128'hDEAD0123_456789AB_CDEF0011_2233BEEF;
    pat_b = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
    pat_c = 128'h11112222_33334444_55556666_77778888;

    rst = 1'b1; i_read = 0; d_read = 0; d_write = 0;
    i_addr = '0; d_addr = '0; d_wline = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    chk("lit_reset_busy", busy, 1'b0);
    chk("lit_reset_mem_read", mem_read, 1'b0);
    chk("lit_reset_i_line", i_line, '0);
    rst = 1'b0;

    // I read alone
    run_txn(1'b0, 1'b1, 1'b0, 28'h10, '0, t0, lat, line);
    chk("lit_i_latency", lat, 6);
    chk("lit_i_line", line, 128'hC0DE0010_C0DE0010_C0DE0010_C0DE0010);

    // D write then D read of the same line
    run_txn(1'b1, 1'b0, 1'b1, 28'h20, pat_a, t0, lat, line);
    chk("lit_dw_latency", lat, 6);
    chk("lit_dw_d_line_unchanged", line, '0);
    run_txn(1'b1, 1'b1, 1'b0, 28'h20, '0, t1, lat, line);
    chk("lit_dr_line", line, pat_a);
    chk("lit_grant_period", t1 - t0, 8);

    // both request at first idle after reset
    do_reset();
    @(negedge clk);
    i_read = 1'b1; i_addr = 28'h40; d_read = 1'b1; d_addr = 28'h50;
    t0 = cyc + 1;
    wait_ready(1'b1, td);
    chk("lit_tie_d_first_lat", td - t0, 6);
    chk("lit_tie_gnt_d1", gnt_d, 1'b1);
    chk("lit_tie_d_line", d_line, 128'hC0DE0050_C0DE0050_C0DE0050_C0DE0050);
    d_read = 1'b0;
    wait_ready(1'b0, ti);
    chk("lit_tie_i_done", ti - t0, 14);
    chk("lit_tie_gnt_d0", gnt_d, 1'b0);
    chk("lit_tie_i_line", i_line, 128'hC0DE0040_C0DE0040_C0DE0040_C0DE0040);
    i_read = 1'b0;

    // both held continuously for four transfers
    @(negedge clk);
    base = gnt_log.size();
    i_read = 1'b1; i_addr = 28'h41; d_read = 1'b1; d_addr = 28'h51;
    nd = 0;
    for (int n = 0; n < 80 && nd < 4; n++) begin
      @(negedge clk);
      if (i_ready || d_ready) nd++;
    end
    i_read = 1'b0; d_read = 1'b0;
    chk("lit_rr_count", nd, 4);
    if (gnt_log.size() >= base + 4) begin
      chk("lit_rr_g0", gnt_log[base], 1'b1);
      chk("lit_rr_g1", gnt_log[base+1], 1'b0);
      chk("lit_rr_g2", gnt_log[base+2], 1'b1);
      chk("lit_rr_g3", gnt_log[base+3], 1'b0);
    end else begin
      checks++; errors++;
      $display("FAIL rr_grants: got %0d grants expected at least %0d", gnt_log.size() - base, 4);
    end

    // read+write together behaves as a write
    run_txn(1'b1, 1'b1, 1'b1, 28'h60, pat_b, t0, lat, line);
    chk("lit_rw_latency", lat, 6);
    run_txn(1'b1, 1'b1, 1'b0, 28'h60, '0, t0, lat, line);
    chk("lit_rw_readback", line, pat_b);

    // reset during a D write abandons it
    @(negedge clk);
    d_write = 1'b1; d_addr = 28'h30; d_wline = pat_c;
    @(negedge clk);
    chk("lit_abort_write_started", mem_write, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b1; d_write = 1'b0;
    @(negedge clk);
    chk("lit_abort_mem_write", mem_write, 1'b0);
    chk("lit_abort_mem_addr", mem_addr, '0);
    chk("lit_abort_mem_wline", mem_wline, '0);
    chk("lit_abort_busy", busy, 1'b0);
    chk("lit_abort_gnt_d", gnt_d, 1'b0);
    chk("lit_abort_d_line", d_line, '0);
    rst = 1'b0;
    run_txn(1'b0, 1'b1, 1'b0, 28'h30, '0, t0, lat, line);
    chk("lit_abort_i_latency", lat, 6);
    chk("lit_abort_not_written", line, 128'hC0DE0030_C0DE0030_C0DE0030_C0DE0030);

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    at = cyc;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
